// File: rtl/irq_ctrl.sv
// Prioritised, maskable interrupt controller with EPC/level stack for the MIPS core.
// Define IRQ_NEST_EN to compile in preemptive nesting with a NEST_DEPTH-entry stack.
module irq_ctrl #(
  parameter int          NUM_IRQ     = 3,
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0800,
  parameter int          VEC_SHIFT   = 6,
  parameter int          NEST_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cpu_run,
  input  logic [31:0]        cpu_npc,
  input  logic               eret,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic               take,
  output logic [31:0]        vector,
  output logic [31:0]        epc,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic               err
);

`ifdef IRQ_NEST_EN
  localparam int DEPTH = NEST_DEPTH;
`else
  localparam int DEPTH = 1;
`endif
  localparam int LW    = $clog2(NUM_IRQ + 1);
  localparam int SPW   = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << AW;

  typedef struct packed {
    logic [31:0]   pc;
    logic [LW-1:0] lvl;
  } frame_t;

  frame_t stack [SLOTS];

  logic [NUM_IRQ-1:0] irq_sync, irq_prev, mask, rise, elig, win_onehot, clr;
  logic [LW-1:0]      cur_lvl, win_lvl, take_lvl;
  logic [SPW-1:0]     sp;
  logic [AW-1:0]      top, below;
  logic [31:0]        win_vec;
  logic               full, do_pop, want, do_take, push_err;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rise       = irq_sync & ~irq_prev;
    elig       = pending & mask;
    win_lvl    = '0;
    win_onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (elig[i]) begin
        win_lvl       = LW'(i + 1);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
    win_vec = VECTOR_BASE + ((32'(win_lvl) - 32'd1) << VEC_SHIFT);

    full  = (sp == SPW'(DEPTH));
    top   = AW'(sp - SPW'(1));
    below = AW'(sp - SPW'(2));

    // An eret coinciding with the push cycle is ignored; the CPU is redirected
    // to the vector in that cycle anyway.
    do_pop  = eret && cpu_run && !take;
    want    = (win_lvl != '0) && (win_lvl > cur_lvl) && cpu_run && !take && !do_pop;
    do_take = want && !full;
`ifdef IRQ_NEST_EN
    push_err = want && full;
`else
    push_err = 1'b0;
`endif
    clr = do_take ? win_onehot : '0;
  end

  // NOTE: the stack body is not reset; sp = 0 already marks every entry invalid.
  always_ff @(posedge clk) begin
    if (take) stack[AW'(sp)] <= '{pc: cpu_npc, lvl: cur_lvl};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_sync   <= '0;
      irq_prev   <= '0;
      pending    <= '0;
      mask       <= '1;
      take       <= 1'b0;
      vector     <= '0;
      take_lvl   <= '0;
      cur_lvl    <= '0;
      sp         <= '0;
      epc        <= '0;
      in_service <= 1'b0;
      err        <= 1'b0;
    end else begin
      irq_sync <= irq_in;
      irq_prev <= irq_sync;
      // A fresh edge wins over the clear so a request arriving at take time is kept.
      pending  <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wdata;

      take <= do_take;
      if (do_take) begin
        vector   <= win_vec;
        take_lvl <= win_lvl;
      end

      if (take) begin
        sp         <= sp + SPW'(1);
        cur_lvl    <= take_lvl;
        epc        <= cpu_npc;
        in_service <= 1'b1;
      end else if (do_pop) begin
        if (sp == '0) begin
          err <= 1'b1;
        end else begin
          sp         <= sp - SPW'(1);
          cur_lvl    <= stack[top].lvl;
          epc        <= (sp > SPW'(1)) ? stack[below].pc : 32'd0;
          in_service <= (sp > SPW'(1));
        end
      end

      if (push_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: expected vectors are queued when a request is
// stimulated and matched against each observed take pulse.
module tb_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  irq_in;
  logic        cpu_run;
  logic [31:0] cpu_npc;
  logic        eret;
  logic        mask_we;
  logic [2:0]  mask_wdata;
  logic        take;
  logic [31:0] vector;
  logic [31:0] epc;
  logic        in_service;
  logic [2:0]  pending;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  bit          prev_take = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  irq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .cpu_run(cpu_run), .cpu_npc(cpu_npc),
    .eret(eret), .mask_we(mask_we), .mask_wdata(mask_wdata), .take(take), .vector(vector),
    .epc(epc), .in_service(in_service), .pending(pending), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Advance one cycle and sample just after the edge; record take pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    if (take) begin
      got_q.push_back(vector);
      checks++;
      if (prev_take) begin
        errors++;
        $display("FAIL take_width: take high in two consecutive cycles at cycle %0d", cycle);
      end
    end
    prev_take = take;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [2:0] lines);
    irq_in = lines;
    tick();
    irq_in = '0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic expect_take(input logic [31:0] v, input int budget, input string name);
    logic [31:0] e, g;
    int n;
    exp_q.push_back(v);
    n = 0;
    while (got_q.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (got_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no take within %0d cycles, required vector %h", name, budget, e);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin
        errors++;
        $display("FAIL %s: vector %h, required %h", name, g, e);
      end
    end
  endtask

  task automatic expect_no_take(input int n, input string name);
    ticks(n);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL %s: unexpected take, vector %h", name, got_q[0]);
    end
    got_q.delete();
  endtask

  task automatic test_reset();
    int start;
    rst_n = 1'b0; irq_in = '0; cpu_run = 1'b1; cpu_npc = 32'h40;
    eret = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    ticks(2);
    checks++;
    if ({take, in_service, pending, epc, err, vector} !== '0) begin
      errors++;
      $display("FAIL reset_state: take=%b in_service=%b pending=%b epc=%h err=%b vector=%h, required all 0",
               take, in_service, pending, epc, err, vector);
    end
    rst_n = 1'b1;
    ticks(2);
    start = cycle;
    pulse(3'b001);
    expect_take(32'h800, 6, "first_take");
    checks++;
    if (cycle - start !== 3) begin
      errors++;
      $display("FAIL take_latency: take at cycle %0d, required 3", cycle - start);
    end
    checks++;
    if (in_service !== 1'b0) begin
      errors++;
      $display("FAIL in_service_early: in_service=%b during take cycle, required 0", in_service);
    end
    tick();
    checks++;
    if (epc !== 32'h40 || in_service !== 1'b1) begin
      errors++;
      $display("FAIL push: epc=%h in_service=%b, required 00000040 1", epc, in_service);
    end
    do_eret();
    checks++;
    if (in_service !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL eret_idle: in_service=%b err=%b, required 0 0", in_service, err);
    end
  endtask

  task automatic test_priority();
    pulse(3'b101);
    expect_take(32'h880, 6, "prio_high");
    tick();
    do_eret();
    expect_take(32'h800, 6, "prio_low");
    tick();
    do_eret();
    ticks(2);
    checks++;
    if (pending !== 3'b000 || in_service !== 1'b0) begin
      errors++;
      $display("FAIL prio_drain: pending=%b in_service=%b, required 000 0", pending, in_service);
    end
  endtask

  task automatic test_mask();
    mask_we = 1'b1; mask_wdata = 3'b110;
    tick();
    mask_we = 1'b0;
    pulse(3'b001);
    expect_no_take(6, "mask_block");
    checks++;
    if (pending !== 3'b001) begin
      errors++;
      $display("FAIL mask_pending: pending=%b, required 001", pending);
    end
    mask_we = 1'b1; mask_wdata = 3'b111;
    tick();
    mask_we = 1'b0;
    expect_take(32'h800, 6, "mask_enable");
    tick();
    do_eret();
  endtask

  task automatic test_nesting();
    pulse(3'b001);
    expect_take(32'h800, 6, "nest_base");
    tick();
    cpu_npc = 32'h900;
    pulse(3'b010);
`ifdef IRQ_NEST_EN
    expect_take(32'h840, 6, "nest_preempt");
    tick();
    checks++;
    if (epc !== 32'h900) begin
      errors++;
      $display("FAIL nest_epc: epc=%h, required 00000900", epc);
    end
    pulse(3'b001);
    expect_no_take(5, "nest_lower_blocked");
    do_eret();
    checks++;
    if (in_service !== 1'b1 || epc !== 32'h40) begin
      errors++;
      $display("FAIL nest_pop1: in_service=%b epc=%h, required 1 00000040", in_service, epc);
    end
    expect_no_take(4, "nest_same_level");
    do_eret();
    checks++;
    if (in_service !== 1'b0 || epc !== 32'h0) begin
      errors++;
      $display("FAIL nest_pop2: in_service=%b epc=%h, required 0 00000000", in_service, epc);
    end
    expect_take(32'h800, 6, "nest_deferred");
    tick();
    do_eret();
`else
    expect_no_take(5, "flat_no_preempt");
    checks++;
    if (pending !== 3'b010) begin
      errors++;
      $display("FAIL flat_pending: pending=%b, required 010", pending);
    end
    do_eret();
    expect_take(32'h840, 6, "flat_deferred");
    tick();
    checks++;
    if (epc !== 32'h900) begin
      errors++;
      $display("FAIL flat_epc: epc=%h, required 00000900", epc);
    end
    do_eret();
`endif
    cpu_npc = 32'h40;
    checks++;
    if (in_service !== 1'b0) begin
      errors++;
      $display("FAIL nest_done: in_service=%b, required 0", in_service);
    end
  endtask

  task automatic test_error_halt();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean: err=%b, required 0", err);
    end
    do_eret();
    checks++;
    if (err !== 1'b1 || in_service !== 1'b0) begin
      errors++;
      $display("FAIL err_underflow: err=%b in_service=%b, required 1 0", err, in_service);
    end
    cpu_run = 1'b0;
    pulse(3'b100);
    expect_no_take(6, "halt_block");
    checks++;
    if (pending !== 3'b100) begin
      errors++;
      $display("FAIL halt_pending: pending=%b, required 100", pending);
    end
    cpu_run = 1'b1;
    expect_take(32'h880, 4, "halt_resume");
    tick();
    checks++;
    if (in_service !== 1'b1) begin
      errors++;
      $display("FAIL halt_service: in_service=%b, required 1", in_service);
    end
  endtask

  task automatic test_reset_mid();
    pulse(3'b001);
    ticks(2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({take, in_service, pending, epc, err} !== '0) begin
      errors++;
      $display("FAIL async_reset: take=%b in_service=%b pending=%b epc=%h err=%b, required all 0",
               take, in_service, pending, epc, err);
    end
    tick();
    rst_n = 1'b1;
    got_q.delete();
    prev_take = 1'b0;
    ticks(2);
    pulse(3'b001);
    expect_take(32'h800, 6, "post_reset_take");
    tick();
    do_eret();
    checks++;
    if (in_service !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_eret: in_service=%b err=%b, required 0 0", in_service, err);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_mask();
    test_nesting();
    test_error_halt();
    test_reset_mid();
    ticks(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
